icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 132 +++++++++++++
 tb/tb_icache.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache -- direct-mapped instruction cache, one 32-bit word per frame.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   imemREN, imemaddr    datapath fetch request / address ([1:0] ignored)
//   ihit, imemload       hit strobe and returned word (0 when no hit)
//   inv                  invalidate all frames at the next edge
//   iREN, iaddr          memory read request / address (driven only in FETCH)
//   iwait, iload         memory busy flag / read data
//   hit_count,miss_count free-running 32-bit statistics (wrap at 2^32)
//
// A miss latches the request address and sits in FETCH until memory drops
// iwait; the fill then lands in the frame and the word hits on the cycle
// after the return to IDLE. Any new address presented during FETCH is
// looked up only once the cache is back in IDLE.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             r_state, w_next;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS];
    logic [31:0]        r_miss_addr;
    logic [31:0]        r_hit_count, r_miss_count;

    logic [IDX_W-1:0]   w_idx, w_fidx;
    logic [TAG_W-1:0]   w_tag, w_ftag;
    logic               w_lookup, w_hit, w_miss, w_fill;

    assign w_idx  = imemaddr[IDX_W+1:2];
    assign w_tag  = imemaddr[31:IDX_W+2];
    assign w_fidx = r_miss_addr[IDX_W+1:2];
    assign w_ftag = r_miss_addr[31:IDX_W+2];

    // Byte-offset bits carry no information for a word cache.
    logic w_unused_offset;
    assign w_unused_offset = ^{imemaddr[1:0]};

    assign w_lookup = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Next-state and per-cycle strobes. inv suppresses the lookup entirely
    // in IDLE (no hit, no miss); the request is re-evaluated next cycle.
    always_comb begin
        w_next = r_state;
        w_hit  = 1'b0;
        w_miss = 1'b0;
        w_fill = 1'b0;
        case (r_state)
            IDLE: begin
                if (imemREN && !inv) begin
                    if (w_lookup) begin
                        w_hit = 1'b1;
                    end else begin
                        w_miss = 1'b1;
                        w_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!iwait) begin
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_miss_addr  <= imemaddr;
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (w_hit)
                r_hit_count <= r_hit_count + 32'd1;
        end
    end

    // Invalidate takes priority over a coincident fill's valid write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (inv) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fidx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by the valid bits.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= iload;
        end
    end

    assign ihit       = w_hit;
    assign imemload   = w_hit ? r_data[w_idx] : 32'd0;
    assign iREN       = (r_state == FETCH);
    assign iaddr      = (r_state == FETCH) ? r_miss_addr : 32'd0;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (SETS=16). Inputs change on the falling edge;
// outputs are sampled 1 ns later, so each posedge sees stable inputs.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        inv;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_vec = 0;
    int n_err = 0;

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .inv        (inv),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    // Miss on addr, memory busy for 'waits' cycles, then returns data.
    // Ends on the cycle the word hits (request still asserted, so the hit
    // is counted at the following edge).
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
        nxt();
        imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; inv = 1'b0;
        #1;
        chk("miss_ihit", {31'd0, ihit}, 32'd0);
        chk("miss_load", imemload, 32'd0);
        chk("idle_iREN", {31'd0, iREN}, 32'd0);
        for (int i = 0; i <= waits; i++) begin
            nxt();
            iwait = (i < waits);
            iload = (i < waits) ? 32'hDEAD_BEEF : data;
            #1;
            chk("fetch_iREN", {31'd0, iREN}, 32'd1);
            chk("fetch_iaddr", iaddr, addr);
            chk("fetch_ihit", {31'd0, ihit}, 32'd0);
        end
        nxt();
        iwait = 1'b1;
        #1;
        chk("fill_ihit", {31'd0, ihit}, 32'd1);
        chk("fill_load", imemload, data);
        chk("fill_iREN", {31'd0, iREN}, 32'd0);
    endtask

    task automatic idle_counts(input logic [31:0] eh, input logic [31:0] em);
        nxt();
        imemREN = 1'b0; inv = 1'b0; iwait = 1'b1;
        #1;
        chk("hit_count", hit_count, eh);
        chk("miss_count", miss_count, em);
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; inv = 1'b0;
        iwait = 1'b1; iload = '0;
        #2;
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_load", imemload, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        nxt(); nxt();
        nRST = 1'b1;

        // Cold miss: 4 cycles of iREN, then hit.
        do_fill(32'h40, 32'h8C22_0004, 3);
        idle_counts(32'd1, 32'd1);

        // Conflict eviction on index 0.
        do_fill(32'h80, 32'h1111_0080, 1);
        do_fill(32'h40, 32'h8C22_0004, 0);
        idle_counts(32'd3, 32'd3);

        // Redirect during FETCH: fill stays on 0x100.
        nxt();
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        #1 chk("redir_miss", {31'd0, ihit}, 32'd0);
        nxt();
        imemaddr = 32'h200;
        #1 chk("redir_iaddr0", iaddr, 32'h100);
        nxt();
        imemREN = 1'b0;
        #1 chk("redir_iaddr1", iaddr, 32'h100);
        nxt();
        iwait = 1'b0; iload = 32'h0100_AAAA;
        #1 chk("redir_iaddr2", iaddr, 32'h100);
        do_fill(32'h200, 32'h0200_BBBB, 0);
        idle_counts(32'd4, 32'd5);

        // Invalidate with a live request: hit suppressed, then both miss.
        do_fill(32'h0, 32'hD000_0000, 0);
        do_fill(32'h4, 32'hD000_0004, 0);
        nxt();
        imemaddr = 32'h0;
        #1 chk("pre_inv_hit", {31'd0, ihit}, 32'd1);
        chk("pre_inv_load", imemload, 32'hD000_0000);
        nxt();
        inv = 1'b1;
        #1 chk("inv_ihit", {31'd0, ihit}, 32'd0);
        chk("inv_load", imemload, 32'd0);
        do_fill(32'h0, 32'hD000_0000, 0);
        do_fill(32'h4, 32'hD000_0004, 0);
        idle_counts(32'd9, 32'd9);

        // inv coincident with fill completion discards the valid write.
        nxt();
        imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        nxt();
        iwait = 1'b0; inv = 1'b1; iload = 32'h0000_0888;
        #1 chk("invfill_iREN", {31'd0, iREN}, 32'd1);
        do_fill(32'h8, 32'h0000_0888, 0);
        idle_counts(32'd10, 32'd11);

        // Reset mid-fill.
        nxt();
        imemREN = 1'b1; imemaddr = 32'hC; iwait = 1'b1;
        nxt();
        #1 chk("prerst_iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rstmid_iREN", {31'd0, iREN}, 32'd0);
        chk("rstmid_iaddr", iaddr, 32'd0);
        chk("rstmid_hits", hit_count, 32'd0);
        chk("rstmid_misses", miss_count, 32'd0);
        nxt();
        nRST = 1'b1; imemREN = 1'b0;
        do_fill(32'hC, 32'h0000_0CCC, 1);
        idle_counts(32'd1, 32'd1);

        // Hit counter wrap.
        force dut.r_hit_count = 32'hFFFF_FFFF;
        #1 release dut.r_hit_count;
        #1 chk("wrap_pre", hit_count, 32'hFFFF_FFFF);
        nxt();
        imemREN = 1'b1; imemaddr = 32'hC;
        #1 chk("wrap_hit", {31'd0, ihit}, 32'd1);
        idle_counts(32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
